// File: rtl/ddr_stats_poller_pkg.sv
// Shared definitions for the DDR statistics poller.
// Holds the stats window geometry, the register offsets the sweep reads,
// the stats index names, AXI response codes, the sweep FSM state type and
// a helper that maps a sweep read index to its AXI-Lite address.
package ddr_stats_pkg;

    localparam int NUM_STATS_REGS = 13;
    localparam int NUM_SWEEP_READS = 17;

    localparam logic [31:0] STATS_DATA_OFFSET = 32'h0000_0020;
    localparam logic [31:0] READ_LEN_OFFSET   = 32'h0000_0060;
    localparam logic [31:0] WRITE_LEN_OFFSET  = 32'h0000_0080;

    // Stats index order as returned by the auto-incrementing data register.
    localparam int WRITE_CMD   = 0;
    localparam int WRITE_DATA  = 1;
    localparam int WRITE_RESP  = 2;
    localparam int READ_CMD    = 3;
    localparam int READ_DATA   = 4;
    localparam int READ_RESP   = 5;
    localparam int WRITE_STALL = 6;
    localparam int READ_STALL  = 7;
    localparam int FIFO_OVF    = 8;
    localparam int FIFO_UNF    = 9;
    localparam int DECERR_CNT  = 10;
    localparam int SLVERR_CNT  = 11;
    localparam int DM_ERRORS   = 12;

    localparam logic [1:0] AXI_RESP_OK     = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Reads 0..12 hit the stats data register, 13/14 the read length pair,
    // 15/16 the write length pair.
    function automatic logic [31:0] sweep_addr(input logic [31:0] base,
                                               input logic [4:0]  idx);
        if (idx < 5'd13) begin
            return base + STATS_DATA_OFFSET;
        end else if (idx < 5'd15) begin
            return base + READ_LEN_OFFSET;
        end else begin
            return base + WRITE_LEN_OFFSET;
        end
    endfunction

endpackage

// File: rtl/ddr_stats_poller_if.sv
// AXI-Lite bus between the stats poller (master) and the stats responder
// (slave). All five channels are carried; the poller only uses AR and R and
// ties off the write side.
interface ddr_stats_poller_if;

    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport master (
        output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );

    modport slave (
        input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );

endinterface

// File: rtl/ddr_stats_poller_axil_single_read.sv
// Single-beat AXI-Lite read engine.
// Request side : req_addr/req_valid in, req_ready out (AR accepted).
// Response side: rsp_data/rsp_resp/rsp_valid out (R accepted this cycle).
// AXI side     : m_araddr/m_arvalid/m_arready, m_rdata/m_rresp/m_rvalid/m_rready.
// timeout_hit  : high while the current AR or R wait has lasted TIMEOUT_CYCLES.
module axil_single_read #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] req_addr,
    input  logic        req_valid,
    output logic        req_ready,
    output logic [31:0] rsp_data,
    output logic [1:0]  rsp_resp,
    output logic        rsp_valid,
    output logic        timeout_hit,
    output logic [31:0] m_araddr,
    output logic        m_arvalid,
    input  logic        m_arready,
    input  logic [31:0] m_rdata,
    input  logic [1:0]  m_rresp,
    input  logic        m_rvalid,
    output logic        m_rready
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    logic             pend_q, pend_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ar_hs, r_hs, waiting;

    // AR is only offered while no read is outstanding, so AR and R are
    // never active together.
    assign m_araddr  = req_addr;
    assign m_arvalid = req_valid & ~pend_q;
    assign m_rready  = pend_q;
    assign req_ready = m_arready & ~pend_q;

    assign rsp_data  = m_rdata;
    assign rsp_resp  = m_rresp;
    assign rsp_valid = m_rvalid & pend_q;

    assign ar_hs   = m_arvalid & m_arready;
    assign r_hs    = m_rvalid & m_rready;
    assign waiting = m_arvalid | pend_q;

    assign timeout_hit = (cnt_q == CNT_MAX);

    always_comb begin
        pend_d = pend_q;
        cnt_d  = cnt_q;
        if (ar_hs) begin
            pend_d = 1'b1;
        end else if (r_hs) begin
            pend_d = 1'b0;
        end
        // Counter restarts on every handshake and saturates at the limit;
        // the transaction itself is never abandoned.
        if (!waiting || ar_hs || r_hs) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/ddr_stats_poller.sv
// DDR datamover statistics poller.
// Each accepted start performs one sweep of 17 single-beat AXI-Lite reads
// (13 stats words, then read/write length counter low/high halves) and
// publishes the results as one coherent snapshot together with a done pulse.
// Ports:
//   mem_clk, mem_reset  clock and synchronous active-high reset
//   start               begin a sweep (ignored unless idle)
//   busy                sweep in progress (ADDR/DATA)
//   done                one-cycle pulse; snapshot valid from this cycle
//   resp_err            last sweep saw a non-OKAY rresp
//   timeout             sticky AR/R wait timeout, cleared by next start
//   m_axil              AXI-Lite master (read-only use; write side tied off)
//   stats_words         13 x 32-bit stats snapshot, word k at [32k+31:32k]
//   ddr_read_len/ddr_write_len  48-bit length counter snapshots
module ddr_stats_poller
    import ddr_stats_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int          TIMEOUT_CYCLES = 1024
) (
    input  logic                           mem_clk,
    input  logic                           mem_reset,
    input  logic                           start,
    output logic                           busy,
    output logic                           done,
    output logic                           resp_err,
    output logic                           timeout,
    ddr_stats_poller_if.master             m_axil,
    output logic [NUM_STATS_REGS*32-1:0]   stats_words,
    output logic [47:0]                    ddr_read_len,
    output logic [47:0]                    ddr_write_len
);

    state_e                           state_q, state_d;
    logic [4:0]                       idx_q, idx_d;
    logic                             err_q, err_d;
    logic                             timeout_q, timeout_d;

    // Shadow registers filled during the sweep; only the bits that reach
    // the snapshot are kept (upper halves of the odd length reads drop).
    logic [NUM_STATS_REGS-1:0][31:0]  stats_sh_q, stats_sh_d;
    logic [1:0][31:0]                 len_lo_q, len_lo_d;
    logic [1:0][15:0]                 len_hi_q, len_hi_d;

    logic [NUM_STATS_REGS-1:0][31:0]  snap_stats_q, snap_stats_d;
    logic [47:0]                      snap_rd_len_q, snap_rd_len_d;
    logic [47:0]                      snap_wr_len_q, snap_wr_len_d;
    logic                             resp_err_q, resp_err_d;

    logic                             req_valid, req_ready;
    logic [31:0]                      rsp_data;
    logic [1:0]                       rsp_resp;
    logic                             rsp_valid;
    logic                             timeout_hit;
    logic                             unused_wr_side;

    assign req_valid = (state_q == ST_ADDR);

    axil_single_read #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_rd (
        .clk         (mem_clk),
        .rst         (mem_reset),
        .req_addr    (sweep_addr(BASE_ADDR, idx_q)),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .rsp_data    (rsp_data),
        .rsp_resp    (rsp_resp),
        .rsp_valid   (rsp_valid),
        .timeout_hit (timeout_hit),
        .m_araddr    (m_axil.araddr),
        .m_arvalid   (m_axil.arvalid),
        .m_arready   (m_axil.arready),
        .m_rdata     (m_axil.rdata),
        .m_rresp     (m_axil.rresp),
        .m_rvalid    (m_axil.rvalid),
        .m_rready    (m_axil.rready)
    );

    // The poller never writes.
    assign m_axil.awaddr  = '0;
    assign m_axil.awvalid = 1'b0;
    assign m_axil.wdata   = '0;
    assign m_axil.wstrb   = '0;
    assign m_axil.wvalid  = 1'b0;
    assign m_axil.bready  = 1'b1;
    assign unused_wr_side = ^{m_axil.awready, m_axil.wready, m_axil.bresp, m_axil.bvalid};

    assign busy          = (state_q == ST_ADDR) || (state_q == ST_DATA);
    assign done          = (state_q == ST_DONE);
    assign resp_err      = resp_err_q;
    assign timeout       = timeout_q;
    assign stats_words   = snap_stats_q;
    assign ddr_read_len  = snap_rd_len_q;
    assign ddr_write_len = snap_wr_len_q;

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        err_d         = err_q;
        timeout_d     = timeout_q;
        stats_sh_d    = stats_sh_q;
        len_lo_d      = len_lo_q;
        len_hi_d      = len_hi_q;
        snap_stats_d  = snap_stats_q;
        snap_rd_len_d = snap_rd_len_q;
        snap_wr_len_d = snap_wr_len_q;
        resp_err_d    = resp_err_q;

        if (timeout_hit) begin
            timeout_d = 1'b1;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    idx_d     = '0;
                    err_d     = 1'b0;
                    timeout_d = 1'b0;
                    state_d   = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (req_ready) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (rsp_valid) begin
                    case (idx_q)
                        5'd13:   len_lo_d[0] = rsp_data;
                        5'd14:   len_hi_d[0] = rsp_data[15:0];
                        5'd15:   len_lo_d[1] = rsp_data;
                        5'd16:   len_hi_d[1] = rsp_data[15:0];
                        default: stats_sh_d[idx_q[3:0]] = rsp_data;
                    endcase
                    if (rsp_resp != AXI_RESP_OK) begin
                        err_d = 1'b1;
                    end
                    if (idx_q == 5'd16) begin
                        // Snapshot is loaded from the next-state shadow so the
                        // final word is included and outputs change exactly
                        // as done rises.
                        snap_stats_d  = stats_sh_d;
                        snap_rd_len_d = {len_hi_d[0], len_lo_d[0]};
                        snap_wr_len_d = {len_hi_d[1], len_lo_d[1]};
                        resp_err_d    = err_d;
                        state_d       = ST_DONE;
                    end else begin
                        idx_d   = idx_q + 5'd1;
                        state_d = ST_ADDR;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge mem_clk) begin
        if (mem_reset) begin
            state_q       <= ST_IDLE;
            idx_q         <= '0;
            err_q         <= 1'b0;
            timeout_q     <= 1'b0;
            snap_stats_q  <= '0;
            snap_rd_len_q <= '0;
            snap_wr_len_q <= '0;
            resp_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            err_q         <= err_d;
            timeout_q     <= timeout_d;
            snap_stats_q  <= snap_stats_d;
            snap_rd_len_q <= snap_rd_len_d;
            snap_wr_len_q <= snap_wr_len_d;
            resp_err_q    <= resp_err_d;
        end
    end

    always_ff @(posedge mem_clk) begin
        stats_sh_q <= stats_sh_d;
        len_lo_q   <= len_lo_d;
        len_hi_q   <= len_hi_d;
    end

endmodule

// File: tb/tb_ddr_stats_poller.sv
// Bench for ddr_stats_poller: a behavioural stats responder (auto-incrementing
// stats pointer mod 13, toggling length halves) with random back-pressure,
// error and stall injection; snapshots are compared against the responder's
// own data tables.
module tb_ddr_stats_poller;
    import ddr_stats_pkg::*;

    localparam logic [31:0] BASE = 32'h4000_1000;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         busy, done, resp_err, timeout;
    logic [415:0] stats_words;
    logic [47:0]  ddr_read_len, ddr_write_len;

    always #5 clk = ~clk;

    ddr_stats_poller_if axil();

    ddr_stats_poller #(
        .BASE_ADDR      (BASE),
        .TIMEOUT_CYCLES (1024)
    ) dut (
        .mem_clk       (clk),
        .mem_reset     (rst),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .resp_err      (resp_err),
        .timeout       (timeout),
        .m_axil        (axil.master),
        .stats_words   (stats_words),
        .ddr_read_len  (ddr_read_len),
        .ddr_write_len (ddr_write_len)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Responder model state
    logic [31:0] st_val [13];
    logic [47:0] rd_len_v, wr_len_v;
    int ptr = 0;
    bit rd_half = 0, wr_half = 0;
    int ar_max = 0, r_max = 0;
    int err_stat = -1;
    int stall_read = -1;
    int reads_served = 0;
    int ar_hs_cnt = 0;
    int addr_bad = 0;

    // Monitors
    bit           mon_en = 0;
    int           hold_bad = 0, both_bad = 0, addr_chg = 0;
    logic [512:0] prev_snap;
    logic         prev_arvalid = 0;
    logic [31:0]  prev_araddr = '0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (!done && {stats_words, ddr_read_len, ddr_write_len, resp_err} !== prev_snap)
                hold_bad++;
            if (axil.arvalid && axil.rready)
                both_bad++;
            if (axil.arvalid && prev_arvalid && axil.araddr !== prev_araddr)
                addr_chg++;
        end
        prev_snap    = {stats_words, ddr_read_len, ddr_write_len, resp_err};
        prev_arvalid = axil.arvalid;
        prev_araddr  = axil.araddr;
    end

    task automatic serve();
        logic [31:0] a, d, exp_a;
        logic [1:0]  rr;
        int          dly;
        bit          r;
        dly = $urandom_range(ar_max, 0);
        repeat (dly) @(negedge clk);
        a = axil.araddr;
        axil.arready = 1'b1;
        @(negedge clk);
        axil.arready = 1'b0;
        ar_hs_cnt++;
        exp_a = (reads_served < 13) ? BASE + 32'h20 :
                (reads_served < 15) ? BASE + 32'h60 : BASE + 32'h80;
        if (a !== exp_a) addr_bad++;
        rr = 2'b00;
        if (a == BASE + 32'h20) begin
            d = st_val[ptr];
            if (ptr == err_stat) rr = 2'b10;
            ptr = (ptr + 1) % 13;
        end else if (a == BASE + 32'h60) begin
            d = rd_half ? {16'($urandom), rd_len_v[47:32]} : rd_len_v[31:0];
            rd_half = !rd_half;
        end else if (a == BASE + 32'h80) begin
            d = wr_half ? {16'($urandom), wr_len_v[47:32]} : wr_len_v[31:0];
            wr_half = !wr_half;
        end else begin
            d = $urandom;
        end
        if (reads_served == stall_read) begin
            repeat (1000) @(negedge clk);
            check_val("tmo_early", timeout, 1'b0);
            repeat (100) @(negedge clk);
            check_val("tmo_set", timeout, 1'b1);
        end else begin
            dly = $urandom_range(r_max, 0);
            repeat (dly) @(negedge clk);
        end
        reads_served++;
        axil.rdata  = d;
        axil.rresp  = rr;
        axil.rvalid = 1'b1;
        do begin
            r = axil.rready;
            @(negedge clk);
        end while (!r);
        axil.rvalid = 1'b0;
        axil.rresp  = 2'b00;
    endtask

    initial begin : responder
        axil.arready = 1'b0;
        axil.rdata   = '0;
        axil.rresp   = 2'b00;
        axil.rvalid  = 1'b0;
        axil.awready = 1'b0;
        axil.wready  = 1'b0;
        axil.bresp   = 2'b00;
        axil.bvalid  = 1'b0;
        forever begin
            if (axil.arvalid === 1'b1 && rst === 1'b0) serve();
            else @(negedge clk);
        end
    end

    task automatic randomize_data();
        for (int k = 0; k < 13; k++) st_val[k] = $urandom;
        rd_len_v = {16'($urandom), 32'($urandom)};
        wr_len_v = {16'($urandom), 32'($urandom)};
    endtask

    // One sweep; exp_lat=0 skips the latency check.
    task automatic run_sweep(input string nm, input bit spam, input bit exp_err,
                             input bit exp_tmo, input int exp_lat);
        int n;
        bit got;
        ar_hs_cnt    = 0;
        reads_served = 0;
        addr_bad     = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n   = 1;
        got = 0;
        check_val({nm, "_busy_on"}, busy, 1'b1);
        check_val({nm, "_tmo_clr"}, timeout, 1'b0);
        while (!got && n < 5000) begin
            if (done === 1'b1) begin
                got = 1;
            end else begin
                start = (spam && (n == 5 || n == 20)) ? 1'b1 : 1'b0;
                @(negedge clk);
                n++;
            end
        end
        start = 1'b0;
        check_val({nm, "_done_seen"}, got, 1'b1);
        if (!got) return;
        // Start cycle counts as cycle 1, so done at cycle 36 is 35 cycles later.
        if (exp_lat != 0) check_val({nm, "_latency"}, n, exp_lat);
        check_val({nm, "_busy_at_done"}, busy, 1'b0);
        for (int k = 0; k < 13; k++)
            check_val($sformatf("%s_word%0d", nm, k), stats_words[32*k +: 32], st_val[k]);
        check_val({nm, "_rd_len"}, ddr_read_len, rd_len_v);
        check_val({nm, "_wr_len"}, ddr_write_len, wr_len_v);
        check_val({nm, "_resp_err"}, resp_err, exp_err);
        check_val({nm, "_timeout"}, timeout, exp_tmo);
        // start in the done cycle must be ignored
        if (spam) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_val({nm, "_idle_busy"}, busy, 1'b0);
        check_val({nm, "_idle_arvalid"}, axil.arvalid, 1'b0);
        repeat (3) @(negedge clk);
        check_val({nm, "_ar_count"}, ar_hs_cnt, 17);
        check_val({nm, "_addr_seq"}, addr_bad, 0);
        check_val({nm, "_ptr"}, ptr, 0);
        check_val({nm, "_halves"}, {rd_half, wr_half}, 2'b00);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish, got hang expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int w;
        for (int k = 0; k < 13; k++) st_val[k] = 32'h100 + k;
        rd_len_v = 48'h0012_3456_789A;
        wr_len_v = 48'h00AB_0000_0001;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_val("rst_busy", busy, 1'b0);
        check_val("rst_done", done, 1'b0);
        check_val("rst_resp_err", resp_err, 1'b0);
        check_val("rst_timeout", timeout, 1'b0);
        check_val("rst_arvalid", axil.arvalid, 1'b0);
        check_val("rst_rready", axil.rready, 1'b0);
        check_val("rst_bready", axil.bready, 1'b1);
        check_val("rst_wr_side", {axil.awvalid, axil.wvalid, axil.wstrb}, 6'd0);
        check_val("rst_stats", |stats_words, 1'b0);
        check_val("rst_lens", {ddr_read_len, ddr_write_len}, 96'd0);
        rst = 1'b0;
        @(negedge clk);
        mon_en = 1;

        run_sweep("zero_wait", 0, 0, 0, 35);

        ar_max = 7;
        r_max  = 7;
        for (int i = 0; i < 3; i++) begin
            randomize_data();
            run_sweep("backpressure", 0, 0, 0, 0);
        end

        randomize_data();
        err_stat = 5;
        run_sweep("slverr", 0, 1, 0, 0);
        err_stat = -1;
        randomize_data();
        run_sweep("clean_after_err", 0, 0, 0, 0);

        ar_max = 0;
        r_max  = 0;
        randomize_data();
        stall_read = 7;
        run_sweep("stall", 0, 0, 1, 0);
        stall_read = -1;
        randomize_data();
        run_sweep("after_stall", 0, 0, 0, 35);

        ar_max = 3;
        r_max  = 3;
        randomize_data();
        run_sweep("start_spam", 1, 0, 0, 0);
        randomize_data();
        run_sweep("back2back", 0, 0, 0, 0);

        check_val("araddr_stable", addr_chg, 0);
        check_val("ar_r_exclusive", both_bad, 0);
        check_val("snapshot_hold", hold_bad, 0);

        // Reset in the middle of a read's DATA phase
        mon_en = 0;
        ar_max = 0;
        r_max  = 4;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        w = 0;
        while (!(axil.rready === 1'b1 && reads_served >= 3) && w < 500) begin
            @(negedge clk);
            w++;
        end
        check_val("reach_data", axil.rready, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check_val("mid_rst_arvalid", axil.arvalid, 1'b0);
        check_val("mid_rst_rready", axil.rready, 1'b0);
        check_val("mid_rst_busy", busy, 1'b0);
        check_val("mid_rst_stats", |stats_words, 1'b0);
        check_val("mid_rst_lens", {ddr_read_len, ddr_write_len}, 96'd0);
        check_val("mid_rst_resp_err", resp_err, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/ddr_stats_poller.md
# ddr_stats_poller

AXI-Lite read initiator that sweeps the DDR datamover statistics window and publishes one coherent snapshot per sweep. It sits on the memory-clock side of the AXI-Lite clock converter, in place of the host, and drives the stats responder's read channel. Each sweep issues 17 single-beat reads: 13 auto-incrementing stats words, then the lower and upper halves of the 48-bit read and write length counters. It never writes.

## Interface
Parameters:
- BASE_ADDR, 32'h0000_0000, base address of the stats window.
- TIMEOUT_CYCLES, 1024, number of cycles waiting on AR or R before the timeout flag is raised.

Ports:
- mem_clk  in  1  clock.
- mem_reset  in  1  reset; synchronous, active-high.
- start  in  1  pulse; begins a sweep when idle.
- busy  out  1  high from the cycle after an accepted start until the cycle before done.
- done  out  1  one-cycle pulse; snapshot outputs updated in the same cycle.
- resp_err  out  1  last completed sweep saw at least one rresp != OKAY.
- timeout  out  1  sticky; cleared by the next accepted start.
- m_axil_araddr  out  32  read address.
- m_axil_arvalid  out  1  read address valid.
- m_axil_arready  in  1  read address ready.
- m_axil_rdata  in  32  read data.
- m_axil_rresp  in  2  read response.
- m_axil_rvalid  in  1  read data valid.
- m_axil_rready  out  1  read data ready.
- m_axil_awaddr/awvalid/wdata/wstrb/wvalid  out  32/1/32/4/1  tied to 0.
- m_axil_bready  out  1  tied to 1.
- m_axil_bvalid/bresp/awready/wready  in  1/2/1/1  ignored.
- stats_words  out  416  13×32; word k occupies bits [32k+31:32k], in stats index order 0x00..0x0C.
- ddr_read_len  out  48  read length counter.
- ddr_write_len  out  48  write length counter.

## Operation
- FSM states: IDLE, ADDR, DATA, DONE.
- IDLE: on start, clear idx (0..16), the shadow error bit and timeout, then go to ADDR. start is ignored in every other state.
- ADDR: arvalid=1. araddr is BASE_ADDR+0x20 for idx 0–12, BASE_ADDR+0x60 for idx 13–14, BASE_ADDR+0x80 for idx 15–16. On arvalid&&arready, go to DATA.
- DATA: rready=1. On rvalid&&rready:
  - write rdata into shadow slot idx;
  - if rresp != 2'b00, set the shadow error bit;
  - if idx==16, go to DONE; otherwise idx+1 and go to ADDR.
- Length assembly: low half comes from the even read of each pair (idx 13/15), upper 16 bits from rdata[15:0] of the odd read (idx 14/16). rdata[31:16] of the odd read is discarded.
- DONE: copy shadow → stats_words/ddr_*_len/resp_err, pulse done, go to IDLE.
- Timeout: a counter runs in ADDR and DATA and resets on each handshake. When it reaches TIMEOUT_CYCLES, timeout=1. The FSM keeps waiting; transactions are never abandoned.
- Alignment: the responder's stats pointer (mod 13) and length half-toggles start at 0 after its reset. Every sweep consumes exactly 13 stats reads and an even number of length reads, so alignment is preserved. mem_reset must be asserted together with the responder's reset. mem_reset mid-sweep leaves the responder misaligned; this is the system's responsibility and is not detected here.

## Timing
- Reset values: all outputs 0, except m_axil_bready=1. State is IDLE, idx=0.
- Latency:
  - start → arvalid: 1 cycle.
  - R handshake → next arvalid: 1 cycle.
  - final R handshake → done: 1 cycle.
  - With zero-wait responder: 2 cycles per read, 1+34+1 = 36 cycles from start to done.
- araddr is stable while arvalid=1. arvalid is never dropped before arready.
- rready is high only in DATA. arvalid and rready are never high together.
- Snapshot outputs change only in the done cycle. Between sweeps they hold.
- start in the same cycle as done is ignored (FSM is in DONE, not IDLE).

## Structure
- ddr_stats_pkg holds:
  - NUM_STATS_REGS=13;
  - register offsets 0x20/0x60/0x80;
  - stats index constants (WRITE_CMD..DM_ERRORS);
  - AXI_RESP_OK/SLVERR;
  - the state enum.
- One sub-module, axil_single_read: a single-beat AR/R engine with timeout counter.
  - Request interface: addr/valid/ready.
  - Response interface: data/resp/valid.
- The sweep sequencer and shadow/snapshot registers live in the top module.

## Test plan
- Zero-wait responder model: stats words 0x100+k, read_len 48'h0012_3456_789A, write_len 48'h00AB_0000_0001. start → done at cycle 36, stats_words[k]=0x100+k, ddr_read_len=48'h0012_3456_789A, ddr_write_len=48'h00AB_0000_0001, resp_err=0.
- Random arready/rvalid back-pressure (0–7 cycles): same snapshot, araddr never changes while arvalid=1, 17 AR handshakes exactly.
- Responder returns SLVERR on idx 5 → resp_err=1 at done, stats_words[5]=returned data. Next clean sweep → resp_err=0.
- Responder stalls rvalid 1100 cycles with TIMEOUT_CYCLES=1024 → timeout=1 at cycle 1024 of the wait, sweep still completes, done fires. Next start clears timeout.
- start pulsed while busy and in the done cycle → ignored, exactly one sweep of 17 reads. Two back-to-back sweeps → responder stats pointer back at 0 after each.
- mem_reset asserted mid-DATA → next cycle arvalid=0, rready=0, busy=0, snapshot outputs=0.
